// File: rtl/samples_buffer.sv
// Wishbone B4 responder for the samples port: on-chip word memory with
// classic cycles plus constant, linear and wrap-4/8/16 bursts.
// Ports: clk, rst_n (async, active-low), samples_* Wishbone responder side
//   (cyc/stb/we/addr/mosi/cti/bte in, ack/miso out).
module samples_buffer #(
  parameter int                    DATA_WIDTH = 256,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  samples_cyc_o,
  input  logic                  samples_stb_o,
  input  logic                  samples_we_o,
  output logic                  samples_ack_i,
  input  logic [ADDR_WIDTH-1:0] samples_addr_o,
  input  logic [DATA_WIDTH-1:0] samples_mosi_o,
  output logic [DATA_WIDTH-1:0] samples_miso_i,
  input  logic [2:0]            samples_cti_o,
  input  logic [1:0]            samples_bte_o
);

  localparam int WB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(WB);
  localparam int MAW  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CLASSIC,
    BURST
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic                  r_ack;
  logic                  w_ack_n;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] w_idx_n;
  logic                  r_low;
  logic                  w_low_n;
  logic [DATA_WIDTH-1:0] r_miso;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  w_req;
  logic                  w_is_burst;
  logic                  w_below;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_req_idx;
  logic [ADDR_WIDTH-1:0] w_inc;
  logic [ADDR_WIDTH-1:0] w_mask;
  logic [ADDR_WIDTH-1:0] w_next;
  logic                  w_in;
  logic                  w_in_n;
  logic                  w_wr;
  logic                  w_fetch;

  assign w_req      = samples_cyc_o & samples_stb_o;
  assign w_is_burst = (samples_cti_o == 3'b001)
                    | (samples_cti_o == 3'b010);

  // Borrow out of the subtraction flags addresses below BASE_ADDR.
  assign {w_below, w_off} = {1'b0, samples_addr_o}
                          - {1'b0, BASE_ADDR};
  assign w_req_idx = w_off >> OFFW;

  // Wrap bursts advance only the low index bits; linear keeps a full
  // counter so running off the end stays out of range.
  always_comb begin
    w_mask = '0;
    unique case (samples_bte_o)
      2'b01:   w_mask = ADDR_WIDTH'(3);
      2'b10:   w_mask = ADDR_WIDTH'(7);
      2'b11:   w_mask = ADDR_WIDTH'(15);
      default: w_mask = '0;
    endcase
  end

  assign w_inc  = r_idx + 1'b1;
  assign w_next = (samples_bte_o == 2'b00) ? w_inc
                : (r_idx & ~w_mask) | (w_inc & w_mask);

  assign w_in   = !r_low && (r_idx < DEPTH_W);
  assign w_in_n = !w_low_n && (w_idx_n < DEPTH_W);

  // An ack counts only while the master still holds cyc and stb.
  assign w_wr = r_ack & w_req & samples_we_o & w_in;

  always_comb begin
    w_state_n = r_state;
    w_ack_n   = 1'b0;
    w_idx_n   = r_idx;
    w_low_n   = r_low;
    w_fetch   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_idx_n   = w_req_idx;
          w_low_n   = w_below;
          w_ack_n   = 1'b1;
          w_fetch   = 1'b1;
          w_state_n = w_is_burst ? BURST : CLASSIC;
        end
      end
      CLASSIC: w_state_n = IDLE;
      BURST: begin
        if (!samples_cyc_o) begin
          w_state_n = IDLE;
        end else if (samples_stb_o) begin
          if (!r_ack) begin
            w_ack_n = 1'b1;
            w_fetch = 1'b1;
          end else if (samples_cti_o == 3'b111) begin
            w_state_n = IDLE;
          end else begin
            w_ack_n = 1'b1;
            w_fetch = 1'b1;
            if (samples_cti_o == 3'b010) w_idx_n = w_next;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Bypass covers a same-word read right after a write in one burst.
  always_comb begin
    w_rdata = '0;
    if (w_in_n) begin
      if (w_wr && (w_idx_n == r_idx)) w_rdata = samples_mosi_o;
      else w_rdata = mem[w_idx_n[MAW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_idx   <= '0;
      r_low   <= 1'b0;
      r_miso  <= '0;
    end else begin
      r_state <= w_state_n;
      r_ack   <= w_ack_n;
      r_idx   <= w_idx_n;
      r_low   <= w_low_n;
      if (w_fetch) r_miso <= w_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) mem[r_idx[MAW-1:0]] <= samples_mosi_o;
  end

  assign samples_ack_i  = r_ack;
  assign samples_miso_i = r_miso;

endmodule

// File: tb/tb_samples_buffer.sv
// Self-checking bench for samples_buffer: directed Wishbone sequences
// and random bursts against a word-array model of the memory.
module tb_samples_buffer;

  localparam int          DW    = 256;
  localparam int          DEPTH = 1024;
  localparam int          WB    = DW / 8;
  localparam logic [31:0] BASE  = 32'h0;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc   = 1'b0;
  logic          stb   = 1'b0;
  logic          we    = 1'b0;
  logic          ack;
  logic [31:0]   addr  = '0;
  logic [DW-1:0] mosi  = '0;
  logic [DW-1:0] miso;
  logic [2:0]    cti   = '0;
  logic [1:0]    bte   = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mdl  [DEPTH];
  logic [DW-1:0] bdat [16];
  logic [DW-1:0] rdat [16];
  logic [DW-1:0] last_rd;

  always #5 clk = ~clk;

  samples_buffer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(32),
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .samples_cyc_o(cyc),
    .samples_stb_o(stb),
    .samples_we_o(we),
    .samples_ack_i(ack),
    .samples_addr_o(addr),
    .samples_mosi_o(mosi),
    .samples_miso_i(miso),
    .samples_cti_o(cti),
    .samples_bte_o(bte)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic c, input logic s, input logic w,
                     input logic [31:0] a, input logic [DW-1:0] d,
                     input logic [2:0] t, input logic [1:0] b);
    cyc  = c;
    stb  = s;
    we   = w;
    addr = a;
    mosi = d;
    cti  = t;
    bte  = b;
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] mread(input int idx);
    if (idx < 0 || idx >= DEPTH) return '0;
    return mdl[idx];
  endfunction

  function automatic int widx(input logic [31:0] a);
    if (a < BASE) return -1;
    return int'((a - BASE) / WB);
  endfunction

  function automatic logic [31:0] a_of(input int idx);
    return BASE + 32'(idx * WB);
  endfunction

  // Next beat word: constant stays, linear +1, wrap-N cycles in its block.
  function automatic int nxt(input int idx, input logic [2:0] kind,
                             input logic [1:0] b);
    int n;
    if (kind == 3'b001) return idx;
    if (b == 2'b00) return idx + 1;
    n = 4 << (int'(b) - 1);
    return (idx - idx % n) + (idx + 1) % n;
  endfunction

  task automatic classic(input logic w, input logic [31:0] a,
                         input logic [DW-1:0] d, input string tag);
    int idx;
    idx = widx(a);
    drv(1'b1, 1'b1, w, a, d, 3'b000, 2'b00);
    step();
    chk({tag, "_ack"}, ack, 1'b1);
    if (w) begin
      if (idx >= 0 && idx < DEPTH) mdl[idx] = d;
    end else begin
      last_rd = miso;
      chk({tag, "_data"}, miso, mread(idx));
    end
    step();
    drv(1'b0, 1'b0, 1'b0, '0, '0, 3'b000, 2'b00);
    chk({tag, "_ack0"}, ack, 1'b0);
  endtask

  task automatic burst(input logic w, input int i0, input int n,
                       input logic [2:0] kind, input logic [1:0] b,
                       input int stall, input string tag);
    int idx;
    logic [2:0] t;
    idx = i0;
    drv(1'b1, 1'b1, w, a_of(idx), bdat[0], kind, b);
    step();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_ack%0d", tag, k), ack, 1'b1);
      if (w) begin
        if (idx >= 0 && idx < DEPTH) mdl[idx] = bdat[k];
      end else begin
        rdat[k] = miso;
        chk($sformatf("%s_rd%0d", tag, k), miso, mread(idx));
      end
      step();
      if (k < n - 1) begin
        idx = nxt(idx, kind, b);
        t   = (k + 1 == n - 1) ? 3'b111 : kind;
        if (k + 1 == stall) begin
          drv(1'b1, 1'b0, w, a_of(idx), bdat[k+1], t, b);
          step();
          chk({tag, "_stall"}, ack, 1'b0);
          drv(1'b1, 1'b1, w, a_of(idx), bdat[k+1], t, b);
          step();
        end else begin
          drv(1'b1, 1'b1, w, a_of(idx), bdat[k+1], t, b);
        end
      end else begin
        drv(1'b0, 1'b0, 1'b0, '0, '0, 3'b000, 2'b00);
      end
    end
    chk({tag, "_end"}, ack, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d1;
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
    logic          rw;
    logic [2:0]    rk;
    logic [1:0]    rb;
    int            rn;
    int            ri;

    drv(1'b0, 1'b0, 1'b0, '0, '0, 3'b000, 2'b00);
    step();
    step();
    chk("rst_ack", ack, 1'b0);
    chk("rst_miso", miso, '0);
    rst_n = 1'b1;
    step();

    d1 = rnd();
    classic(1'b1, 32'h20, d1, "cl_wr");
    classic(1'b0, 32'h20, '0, "cl_rd");
    chk("cl_rd_d1", last_rd, d1);

    for (int k = 0; k < 4; k++) bdat[k] = DW'(8'hA0 + k);
    burst(1'b1, 0, 4, 3'b010, 2'b00, -1, "lin_wr");
    burst(1'b0, 0, 4, 3'b010, 2'b00, -1, "lin_rd");
    burst(1'b0, widx(32'h40), 4, 3'b010, 2'b01, -1, "wrap4");
    for (int k = 0; k < 4; k++)
      chk($sformatf("wrap4_ord%0d", k), rdat[k],
          DW'(8'hA0 + (k + 2) % 4));

    classic(1'b0, BASE + 32'(DEPTH * WB), '0, "oor_rd");
    chk("oor_rd_zero", last_rd, '0);
    classic(1'b1, BASE + 32'(DEPTH * WB), rnd(), "oor_wr");
    classic(1'b0, a_of(0), '0, "oor_w0");
    chk("oor_w0_kept", last_rd, DW'(8'hA0));

    x0 = rnd();
    x1 = rnd();
    drv(1'b1, 1'b1, 1'b1, a_of(0), x0, 3'b010, 2'b00);
    step();
    chk("drop_ack_b0", ack, 1'b1);
    step();
    drv(1'b1, 1'b1, 1'b1, a_of(1), x1, 3'b010, 2'b00);
    chk("drop_ack_b1", ack, 1'b1);
    step();
    mdl[0] = x0;
    mdl[1] = x1;
    drv(1'b0, 1'b0, 1'b1, a_of(2), rnd(), 3'b010, 2'b00);
    step();
    chk("drop_ack0", ack, 1'b0);
    classic(1'b0, a_of(0), '0, "drop_w0");
    classic(1'b0, a_of(1), '0, "drop_w1");
    classic(1'b0, a_of(2), '0, "drop_w2");
    chk("drop_w2_kept", last_rd, DW'(8'hA2));

    drv(1'b1, 1'b1, 1'b0, a_of(0), '0, 3'b010, 2'b00);
    step();
    step();
    #1 rst_n = 1'b0;
    #1 chk("rstmid_ack", ack, 1'b0);
    chk("rstmid_miso", miso, '0);
    drv(1'b0, 1'b0, 1'b0, '0, '0, 3'b000, 2'b00);
    rst_n = 1'b1;
    step();
    classic(1'b0, a_of(3), '0, "rstmid_rd");

    bdat[0] = DW'(8'h11);
    bdat[1] = DW'(8'h22);
    bdat[2] = DW'(8'h33);
    burst(1'b1, widx(32'h60), 3, 3'b001, 2'b00, -1, "const_wr");
    classic(1'b0, 32'h60, '0, "const_rd");
    chk("const_rd_33", last_rd, DW'(8'h33));

    for (int k = 0; k < 4; k++) bdat[k] = rnd();
    burst(1'b1, DEPTH - 2, 4, 3'b010, 2'b00, -1, "edge_wr");
    burst(1'b0, DEPTH - 2, 4, 3'b010, 2'b00, 2, "edge_rd");
    classic(1'b0, a_of(0), '0, "edge_w0");
    classic(1'b0, a_of(1), '0, "edge_w1");

    for (int k = 0; k < 4; k++) bdat[k] = rnd();
    burst(1'b1, 4, 4, 3'b010, 2'b00, 1, "stall_wr");
    burst(1'b0, 4, 4, 3'b010, 2'b00, 2, "stall_rd");

    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < 16; k++) bdat[k] = rnd();
      burst(1'b1, h * 16, 16, 3'b010, 2'b00, -1, "fill");
    end

    for (int r = 0; r < 12; r++) begin
      rw = 1'($urandom_range(0, 1));
      rk = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001;
      rb = 2'($urandom_range(0, 3));
      rn = int'($urandom_range(2, 8));
      if (rk == 3'b010 && rb == 2'b00) ri = int'($urandom_range(0, 32 - rn));
      else ri = int'($urandom_range(0, 31));
      for (int k = 0; k < 16; k++) bdat[k] = rnd();
      burst(rw, ri, rn, rk, rb,
            ($urandom_range(0, 2) == 0) ? 1 : -1,
            $sformatf("rnd%0d", r));
      burst(1'b0, ri, rn, rk, rb, -1, $sformatf("rndchk%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
